// File: rtl/fpga_mux_fabric_pkg.sv
// rtl/fpga_mux_fabric_pkg.sv - shared constants and types for the LUT-cell mux fabric
package fpga_fabric_pkg;

    localparam int NCELLS   = 7;
    localparam int LUT_BITS = 32;
    localparam int CFG_W    = LUT_BITS + 1;
    localparam int MODE_BIT = 32;

    // Truth table of a 2:1 mux on LUT inputs {sel, b, a}: out = sel ? b : a
    localparam logic [LUT_BITS-1:0] MUX2_LUT = 32'h0000_00CA;

    typedef logic [CFG_W-1:0] cfg_word_t;
    typedef logic [2:0]       cell_idx_t;

    // Config word for a plain mux cell; mode selects combinational (0) or registered (1)
    function automatic cfg_word_t mux_cfg(input logic mode);
        return {mode, MUX2_LUT};
    endfunction

endpackage

// File: rtl/fpga_mux_fabric_if.sv
// rtl/fpga_mux_fabric_if.sv - data, select, config and output signals of the mux fabric
interface fpga_mux_fabric_if;
    import fpga_fabric_pkg::*;

    logic      i0, i1, i2, i3, i4, i5, i6, i7;
    logic      c1, c2, c3;
    logic      cfg_we;
    cell_idx_t cfg_addr;
    cfg_word_t cfg_data;
    logic      o;

    // Driver side: supplies data, selects and config writes, observes the output
    modport master (
        output i0, i1, i2, i3, i4, i5, i6, i7,
        output c1, c2, c3,
        output cfg_we, cfg_addr, cfg_data,
        input  o
    );

    // Fabric side
    modport slave (
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        input  c1, c2, c3,
        input  cfg_we, cfg_addr, cfg_data,
        output o
    );

endinterface

// File: rtl/fpga_mux_fabric_lut_cell.sv
// rtl/fpga_mux_fabric_lut_cell.sv - one 5-input LUT cell with optional output flop (FPGA_CELL_FF_EN)
module fpga_lut_cell
    import fpga_fabric_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_we,
    input  cfg_word_t i_cfg,
    input  logic      i_a,
    input  logic      i_b,
    input  logic      i_sel,
    output logic      o_y
);

    cfg_word_t           r_cfg;
    logic [LUT_BITS-1:0] w_lut;
    logic [4:0]          w_idx;
    logic                w_comb;

    // LUT inputs 3 and 4 are tied low, so only the bottom 8 entries are reachable
    assign w_lut  = r_cfg[LUT_BITS-1:0];
    assign w_idx  = {2'b00, i_sel, i_b, i_a};
    assign w_comb = w_lut[w_idx];

    // Config storage: cleared on reset, reset wins over a same-cycle write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (i_we) begin
            r_cfg <= i_cfg;
        end
    end

`ifdef FPGA_CELL_FF_EN
    logic r_q;

    // Output flop samples the LUT result every cycle; the mode bit decides whether it is used
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_comb;
        end
    end

    assign o_y = r_cfg[MODE_BIT] ? r_q : w_comb;
`else
    // Mode bit is still stored so software sees a consistent config, but it has no effect here
    logic w_unused_mode;
    assign w_unused_mode = r_cfg[MODE_BIT];
    assign o_y           = w_comb;
`endif

endmodule

// File: rtl/fpga_mux_fabric.sv
// rtl/fpga_mux_fabric.sv - 7 LUT cells in a 4/2/1 tree; cell flops only with FPGA_CELL_FF_EN
module fpga_mux_fabric
    import fpga_fabric_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    fpga_mux_fabric_if.slave   bus
);

    logic [7:0]        w_in;
    logic [NCELLS-1:0] w_we;
    logic [NCELLS-1:0] w_y;

    assign w_in = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};

    // Address 7 matches no cell, so such writes fall on the floor
    for (genvar k = 0; k < NCELLS; k++) begin : g_we
        assign w_we[k] = bus.cfg_we && (bus.cfg_addr == cell_idx_t'(k));
    end

    // Level 1: cells l1..l4 pick between adjacent data inputs under c1
    for (genvar k = 0; k < 4; k++) begin : g_leaf
        fpga_lut_cell u_cell (
            .clock (clock),
            .reset (reset),
            .i_we  (w_we[k]),
            .i_cfg (bus.cfg_data),
            .i_a   (w_in[2*k]),
            .i_b   (w_in[2*k+1]),
            .i_sel (bus.c1),
            .o_y   (w_y[k])
        );
    end

    // Level 2: l5 combines l1/l2, l6 combines l3/l4, both under c2
    for (genvar k = 0; k < 2; k++) begin : g_mid
        fpga_lut_cell u_cell (
            .clock (clock),
            .reset (reset),
            .i_we  (w_we[4+k]),
            .i_cfg (bus.cfg_data),
            .i_a   (w_y[2*k]),
            .i_b   (w_y[2*k+1]),
            .i_sel (bus.c2),
            .o_y   (w_y[4+k])
        );
    end

    // Level 3: l7 is the root and drives the fabric output
    fpga_lut_cell u_root (
        .clock (clock),
        .reset (reset),
        .i_we  (w_we[6]),
        .i_cfg (bus.cfg_data),
        .i_a   (w_y[4]),
        .i_b   (w_y[5]),
        .i_sel (bus.c3),
        .o_y   (w_y[6])
    );

    assign bus.o = w_y[6];

endmodule

// File: tb/tb_fpga_mux_fabric.sv
// tb/tb_fpga_mux_fabric.sv - bench for fpga_mux_fabric, behaviour adapts to FPGA_CELL_FF_EN
module tb_fpga_mux_fabric;
    import fpga_fabric_pkg::*;

`ifdef FPGA_CELL_FF_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fpga_mux_fabric_if bus ();

    fpga_mux_fabric dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [32:0] m_cfg [7];
    logic [6:0]  m_ff;
    logic [7:0]  in_v;
    logic [2:0]  sel_v;

    // Reference: walk the tree level by level; returns {cell outputs, cell LUT results}
    function automatic logic [13:0] model_eval();
        logic [6:0] c;
        logic [6:0] y;
        logic       a, b, s;
        c = '0;
        y = '0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                a = in_v[2*k]; b = in_v[2*k+1]; s = sel_v[0];
            end else if (k < 6) begin
                a = y[2*(k-4)]; b = y[2*(k-4)+1]; s = sel_v[1];
            end else begin
                a = y[4]; b = y[5]; s = sel_v[2];
            end
            c[k] = m_cfg[k][{s, b, a}];
            y[k] = (FF_EN && m_cfg[k][32]) ? m_ff[k] : c[k];
        end
        return {y, c};
    endfunction

    task automatic drive(input logic [7:0] v, input logic [2:0] s);
        in_v = v;
        sel_v = s;
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = v;
        {bus.c3, bus.c2, bus.c1} = s;
        #1;
    endtask

    task automatic tick();
        logic [13:0] e;
        logic        we, rst;
        logic [2:0]  addr;
        logic [32:0] data;
        e    = model_eval();
        we   = bus.cfg_we;
        addr = bus.cfg_addr;
        data = bus.cfg_data;
        rst  = reset;
        @(posedge clock);
        if (rst) begin
            for (int k = 0; k < 7; k++) m_cfg[k] = '0;
            m_ff = '0;
        end else begin
            m_ff = e[6:0];
            if (we && addr != 3'd7) m_cfg[addr] = data;
        end
        #1;
    endtask

    task automatic write(input int addr, input logic [32:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr[2:0];
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [13:0] e;
        e = model_eval();
        n_assert++;
        assert (bus.o === e[13]) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.o, e[13]);
        end
    endtask

    task automatic check_val(input string tag, input logic exp);
        n_assert++;
        assert (bus.o === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.o, exp);
        end
    endtask

    task automatic load_all_mux();
        for (int k = 0; k < 7; k++) write(k, mux_cfg(1'b0));
    endtask

    initial begin
        logic [7:0] v;
        logic       prev;
        logic       bitv;
        for (int k = 0; k < 7; k++) m_cfg[k] = '0;
        m_ff = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        drive(8'hA5, 3'b011);

        // Reset clears everything: output is 0 whatever the inputs
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("reset_out", 1'b0);
        drive(8'hFF, 3'b000);
        check_val("reset_unwritten_zero", 1'b0);

        // All cells as plain muxes: o = i[{c3,c2,c1}]
        load_all_mux();
        drive(8'b0000_0001, 3'b000);
        check_val("mux_i0", 1'b1);

        // One-hot input walked against every select value
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < 8; j++) begin
                v = 8'(1 << j);
                drive(v, 3'(s));
                check_val("onehot_sweep", (s == j));
            end
        end

        // Every input pattern at select 5
        for (int p = 0; p < 256; p++) begin
            v = 8'(p);
            drive(v, 3'b101);
            check_val("sel5_all", v[5]);
        end

        // Registered root: o follows i0 one clock later when flops exist
        drive(8'h00, 3'b000);
        write(6, mux_cfg(1'b1));
        prev = 1'b0;
        check_val("reg_after_write", 1'b0);
        for (int k = 0; k < 6; k++) begin
            bitv = (k % 2 == 0);
            v = {7'($urandom), bitv};
            drive(v, 3'b000);
            check_val("reg_pre_edge", FF_EN ? prev : bitv);
            check_model("reg_pre_model");
            tick();
            check_val("reg_post_edge", bitv);
            prev = bitv;
        end

        // l1 as OR of a,b ignoring sel
        write(6, mux_cfg(1'b0));
        write(0, {1'b0, 32'h0000_00EE});
        drive(8'b0000_0010, 3'b000);
        check_val("or_cell_i1", 1'b1);
        drive(8'b0000_0011, 3'b001);
        check_val("or_cell_sel_ignored", 1'b1);
        drive(8'b1111_1100, 3'b000);
        check_val("or_cell_zero", 1'b0);

        // Reset together with a write: write dropped, fabric fully cleared
        reset = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = mux_cfg(1'b0);
        tick();
        reset = 1'b0;
        bus.cfg_we = 1'b0;
        drive(8'h01, 3'b000);
        check_val("reset_beats_write", 1'b0);
        for (int k = 1; k < 7; k++) write(k, mux_cfg(1'b0));
        drive(8'h01, 3'b000);
        check_val("dropped_write_l1", 1'b0);
        drive(8'h04, 3'b010);
        check_val("other_cells_ok", 1'b1);

        // Address 7 writes nothing
        write(7, '1);
        drive(8'h04, 3'b010);
        check_val("addr7_ignored_a", 1'b1);
        drive(8'h01, 3'b000);
        check_val("addr7_ignored_b", 1'b0);
        drive(8'hFB, 3'b010);
        check_val("addr7_ignored_c", 1'b0);

        // Reset while a registered root holds 1
        write(0, mux_cfg(1'b0));
        write(6, mux_cfg(1'b1));
        drive(8'h01, 3'b000);
        tick();
        check_val("reg_holds_one", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("reset_midop", 1'b0);
        drive(8'hFF, 3'b111);
        check_val("unconfigured_after_reset", 1'b0);
        load_all_mux();
        drive(8'h01, 3'b000);
        check_val("reconfigured", 1'b1);

        // Random configs (random tables and modes) and inputs against the model
        for (int r = 0; r < 24; r++) begin
            write(int'($urandom_range(0, 7)), {1'($urandom), 32'($urandom)});
            check_model("rand_after_write");
            for (int c = 0; c < 6; c++) begin
                drive(8'($urandom), 3'($urandom));
                check_model("rand_comb");
                tick();
                check_model("rand_post_edge");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_mux_fabric.md
Name: fpga_mux_fabric

Overview:
- Minimal FPGA-style fabric of 7 identical configurable LUT cells wired as a fixed 3-level binary tree (4 + 2 + 1 cells).
- Each cell holds 33 configuration bits: a 32-entry truth table (5-input LUT) plus one output-mode bit (combinational or registered).
- With every cell loaded with the 2:1-mux truth table, the fabric acts as an 8:1 multiplexer selected by c1/c2/c3.
- Configuration is written through a simple synchronous write port.

Parameters:
- NCELLS, 7, number of LUT cells (fixed by the tree; not meant to be overridden).
- LUT_BITS, 32, truth-table entries per cell (5 LUT inputs).
- CFG_W, 33, config word width: LUT_BITS plus 1 mode bit.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset.
- i0..i7  in  1 each  data inputs.
- c1  in  1  level-1 select.
- c2  in  1  level-2 select.
- c3  in  1  level-3 select.
- cfg_we  in  1  config write enable.
- cfg_addr  in  3  cell index 0..6, mapping to cells l1..l7.
- cfg_data  in  33  [31:0] truth table, [32] mode bit.
- o  out  1  fabric output, which is the output of cell l7.

Behaviour:
- Cell LUT index is the 5-bit value {1'b0, 1'b0, sel, b, a}. The combinational result is mem[index]; LUT inputs 3 and 4 are tied to 0.
- Cell wiring:
  - l1: a=i0, b=i1, sel=c1.
  - l2: a=i2, b=i3, sel=c1.
  - l3: a=i4, b=i5, sel=c1.
  - l4: a=i6, b=i7, sel=c1.
  - l5: a=l1, b=l2, sel=c2.
  - l6: a=l3, b=l4, sel=c2.
  - l7: a=l5, b=l6, sel=c3.
  - o = l7.
- Mode bit mem[32]:
  - 0: cell output is combinational, with zero latency.
  - 1: cell output is a flop capturing the combinational result on each rising clock edge, adding 1 cycle per registered cell on the path.
- Mux truth table: 0x000000CA with mode 0 gives out = sel ? b : a. With all 7 cells loaded this way, o = i[{c3,c2,c1}] combinationally.
- Config write: on a rising edge with cfg_we=1 and reset=0, mem of cell cfg_addr becomes cfg_data. The new function is visible at o from that edge on.
- cfg_addr = 7: the write is ignored and no cell changes.
- Reset (synchronous, active-high) clears all config memories and all cell flops to 0, so o = 0 after reset whatever the inputs.
- Reset has priority over a simultaneous cfg_we; the write is dropped.
- A write to one cell leaves the other cells' config and flop state untouched.
- No X propagation from unwritten cells after reset; they read all-zero.

Optional Feature:
- Macro: FPGA_CELL_FF_EN.
- Defined: the per-cell output flop exists and mem[32] selects registered or combinational output, as described above.
- Undefined: no cell flops are synthesized. mem[32] is still stored, but every cell is purely combinational regardless of it.

Decomposition:
- Package fpga_fabric_pkg:
  - Constants NCELLS, LUT_BITS, CFG_W, MODE_BIT=32.
  - Constant MUX2_LUT = 32'h000000CA.
  - Typedef cfg_word_t (33 bits).
  - Typedef cell_idx_t (3 bits).
- Sub-module fpga_lut_cell contains:
  - 33-bit config register with write enable.
  - 5-input LUT read.
  - Optional output flop with mode mux.
- Top level instantiates fpga_lut_cell 7 times and wires the tree.

Test Plan:
1. Reset, then load all 7 cells with {1'b0, 32'hCA}; drive in=8'b00000001, c3..c1=000 -> o=1 in the same cycle.
2. Same config, sweep all 8 select values with a one-hot input walking in step -> o=1 only when {c3,c2,c1} equals the set bit's index, otherwise 0. Also check all 256 patterns at select 3'b101 -> o=i5.
3. Load l7 with {1'b1, 32'hCA}, others mode 0; toggle i0 with sel=000 -> o follows i0 exactly one clock later (FPGA_CELL_FF_EN defined); same in the same cycle when undefined.
4. Load l1 with 32'h000000EE (OR of a,b ignoring sel), others mux; in=8'b00000010, sel=000 -> o=1.
5. Assert reset together with cfg_we -> o=0, and a subsequent read of behaviour shows the dropped write had no effect. A write to cfg_addr=7 changes nothing.
6. Reset mid-operation with a registered cell holding 1 -> o=0 on the cycle after the reset edge; the fabric needs full reconfiguration to resume muxing.
